// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit saturating direction counters; zero-latency lookup, EX-stage update.
// Optional BP_STATS_EN enables the resolved-branch / misprediction statistics counters.
module branch_predictor #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_uncond,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispred,
  input  logic            flush_all,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
  } bp_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  logic [ENTRIES-1:0] valid_q;
  bp_entry_t          entry_q [ENTRIES];

  logic [IDX_W-1:0]   lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  bp_entry_t          lk_entry;
  logic [IDX_W-1:0]   up_idx;
  logic [TAG_W-1:0]   up_tag;
  bp_entry_t          up_entry;
  logic               up_hit;
  logic               wr_en;
  bp_entry_t          wr_entry;

  assign lk_idx   = lookup_pc[IDX_W+1:2];
  assign lk_tag   = lookup_pc[TAG_HI:TAG_LO];
  assign up_idx   = upd_pc[IDX_W+1:2];
  assign up_tag   = upd_pc[TAG_HI:TAG_LO];
  assign lk_entry = entry_q[lk_idx];
  assign up_entry = entry_q[up_idx];
  assign up_hit   = valid_q[up_idx] && (up_entry.tag == up_tag);

  // Lookup reads registered state only, so a same-cycle update is not visible until next cycle.
  assign pred_hit    = valid_q[lk_idx] && (lk_entry.tag == lk_tag);
  assign pred_taken  = pred_hit && lk_entry.ctr[1];
  assign pred_target = pred_hit ? lk_entry.target : '0;

  // Next contents of the entry addressed by the update; reset and flush suppress the write.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = up_entry;
    if (upd_valid && !rst && !flush_all) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (upd_uncond) begin
          wr_entry.ctr    = 2'b11;
          wr_entry.target = upd_target;
        end else if (upd_taken) begin
          wr_entry.ctr    = sat_inc(up_entry.ctr);
          wr_entry.target = upd_target;
        end else begin
          wr_entry.ctr    = sat_dec(up_entry.ctr);
        end
      end else if (upd_taken || upd_uncond) begin
        wr_en           = 1'b1;
        wr_entry.tag    = up_tag;
        wr_entry.target = upd_target;
        wr_entry.ctr    = upd_uncond ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Payload storage needs no reset: valid_q gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_q[up_idx] <= wr_entry;
    end
  end

`ifdef BP_STATS_EN
  // Statistics count every resolved update, including ones dropped by a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (upd_valid) begin
      stat_branches <= stat_branches + 32'd1;
      if (upd_mispred) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

  // PC bits outside index/tag and the stats-only input are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{lookup_pc, upd_pc, upd_mispred};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios then randomized traffic
// against an array-based reference model of the BTB rules.
module tb_branch_predictor;

  localparam int unsigned N = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_uncond;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic        flush_all;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  bit          m_valid  [N];
  int unsigned m_tag    [N];
  logic [31:0] m_target [N];
  int          m_ctr    [N];
  int unsigned m_br;
  int unsigned m_mp;

  branch_predictor #(.XLEN(32), .ENTRIES(64), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_uncond(upd_uncond), .upd_target(upd_target), .upd_mispred(upd_mispred),
    .flush_all(flush_all), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % N;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / 256) % 256;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic model_apply();
    int unsigned i;
    if (rst) begin
      foreach (m_valid[k]) m_valid[k] = 1'b0;
      m_br = 0;
      m_mp = 0;
    end else begin
      if (upd_valid) begin
        m_br++;
        if (upd_mispred) m_mp++;
      end
      if (flush_all) begin
        foreach (m_valid[k]) m_valid[k] = 1'b0;
      end else if (upd_valid) begin
        i = idx_of(upd_pc);
        if (m_hit(upd_pc)) begin
          if (upd_uncond) begin
            m_ctr[i] = 3;
            m_target[i] = upd_target;
          end else if (upd_taken) begin
            m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
            m_target[i] = upd_target;
          end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
          end
        end else if (upd_taken || upd_uncond) begin
          m_valid[i]  = 1'b1;
          m_tag[i]    = tag_of(upd_pc);
          m_target[i] = upd_target;
          m_ctr[i]    = upd_uncond ? 3 : 2;
        end
      end
    end
  endtask

  // Check all outputs against the model (pre-edge contents), then clock and advance the model.
  task automatic step(input string tag);
    bit h;
    logic [31:0] exp_br;
    logic [31:0] exp_mp;
    #2;
    h = m_hit(lookup_pc);
`ifdef BP_STATS_EN
    exp_br = m_br;
    exp_mp = m_mp;
`else
    exp_br = 32'd0;
    exp_mp = 32'd0;
`endif
    chk({tag, ".hit"},    32'(pred_hit),    32'(h));
    chk({tag, ".taken"},  32'(pred_taken),  32'(h && (m_ctr[idx_of(lookup_pc)] >= 2)));
    chk({tag, ".target"}, pred_target,      h ? m_target[idx_of(lookup_pc)] : 32'd0);
    chk({tag, ".st_br"},  stat_branches,    exp_br);
    chk({tag, ".st_mp"},  stat_mispred,     exp_mp);
    @(posedge clk);
    model_apply();
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                         input logic un, input logic [31:0] tg, input logic mp);
    upd_valid   = v;
    upd_pc      = pc;
    upd_taken   = tk;
    upd_uncond  = un;
    upd_target  = tg;
    upd_mispred = mp;
  endtask

  task automatic idle();
    set_upd(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] pool_idx [4];
    logic [31:0] pc;
    pool_idx[0] = 32'd0; pool_idx[1] = 32'd1; pool_idx[2] = 32'd5; pool_idx[3] = 32'd63;

    rst = 1'b1;
    flush_all = 1'b0;
    lookup_pc = 32'h100;
    idle();
    repeat (2) @(posedge clk);
    model_apply();
    #1;
    rst = 1'b0;

    // Reset state
    #2;
    chk("rst.hit",    32'(pred_hit),    32'd0);
    chk("rst.taken",  32'(pred_taken),  32'd0);
    chk("rst.target", pred_target,      32'd0);
    chk("rst.st_br",  stat_branches,    32'd0);
    chk("rst.st_mp",  stat_mispred,     32'd0);
    step("rst_step");

    // Allocation: same-cycle lookup misses, next cycle hits weakly-taken
    set_upd(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b0);
    #2 chk("alloc_same.hit", 32'(pred_hit), 32'd0);
    step("alloc");
    idle();
    #2;
    chk("alloc_next.hit",    32'(pred_hit),   32'd1);
    chk("alloc_next.taken",  32'(pred_taken), 32'd1);
    chk("alloc_next.target", pred_target,     32'h200);
    step("alloc_next");

    // Saturating decrement to 00, then one taken to 01
    for (int k = 0; k < 3; k++) begin
      set_upd(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
      step("nt_upd");
      idle();
      #2 chk("nt.taken", 32'(pred_taken), 32'd0);
      step("nt_look");
    end
    set_upd(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b0);
    step("tk_upd");
    idle();
    #2;
    chk("tk01.hit",   32'(pred_hit),   32'd1);
    chk("tk01.taken", 32'(pred_taken), 32'd0);
    step("tk01");

    // Alias at index 0 with tag 0x02
    lookup_pc = 32'h200;
    #2 chk("alias.hit", 32'(pred_hit), 32'd0);
    step("alias_look");
    set_upd(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 1'b0);
    step("alias_upd");
    idle();
    lookup_pc = 32'h100;
    #2 chk("alias_old.hit", 32'(pred_hit), 32'd0);
    step("alias_old");
    lookup_pc = 32'h200;
    #2 chk("alias_new.target", pred_target, 32'h300);
    step("alias_new");

    // Reset during an update discards it
    rst = 1'b1;
    set_upd(1'b1, 32'h400, 1'b1, 1'b1, 32'h500, 1'b1);
    @(posedge clk);
    model_apply();
    #1;
    rst = 1'b0;
    idle();
    lookup_pc = 32'h400;
    #2 chk("rstupd.hit", 32'(pred_hit), 32'd0);
    step("rstupd");
    lookup_pc = 32'h200;
    step("rstupd_old");

    // Five updates (two mispredicted), then flush
    for (int k = 0; k < 5; k++) begin
      set_upd(1'b1, 32'h10 + 32'(k * 4), 1'b1, 1'b0, 32'h1000 + 32'(k), 1'(k == 1 || k == 3));
      lookup_pc = 32'h10 + 32'(k * 4);
      step("five");
    end
    idle();
    flush_all = 1'b1;
    step("flush");
    flush_all = 1'b0;
    for (int k = 0; k < 5; k++) begin
      lookup_pc = 32'h10 + 32'(k * 4);
      step("post_flush");
    end
`ifdef BP_STATS_EN
    chk("flush.st_br", stat_branches, 32'd5);
    chk("flush.st_mp", stat_mispred,  32'd2);
`endif

    // Flush and update in the same cycle: update dropped, still counted
    flush_all = 1'b1;
    set_upd(1'b1, 32'h20, 1'b1, 1'b1, 32'h2000, 1'b1);
    step("flush_upd");
    flush_all = 1'b0;
    idle();
    lookup_pc = 32'h20;
    #2 chk("flush_upd.hit", 32'(pred_hit), 32'd0);
    step("flush_upd_look");

    // Randomized traffic over a small alias-heavy PC pool
    for (int n = 0; n < 800; n++) begin
      pc = (32'($urandom_range(0, 2)) << 8) | (pool_idx[$urandom_range(0, 3)] << 2) | 32'($urandom_range(0, 3));
      set_upd(1'($urandom_range(0, 9) < 6), pc, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 5) == 0), $urandom, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        lookup_pc = pc;
      end else begin
        lookup_pc = (32'($urandom_range(0, 2)) << 8) | (pool_idx[$urandom_range(0, 3)] << 2)
                    | 32'($urandom_range(0, 3));
      end
      flush_all = 1'($urandom_range(0, 39) == 0);
      rst       = 1'($urandom_range(0, 149) == 0);
      step("rand");
    end
    rst = 1'b0;
    flush_all = 1'b0;
    idle();
    step("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
